mem_wb_stage: RTL and testbench

//  MEM/WB pipeline register plus writeback logic; sits directly upstream of the register file.

---
 rtl/wb_pkg.sv | 47 ++++
 rtl/load_extend.sv | 44 ++++
 rtl/mem_wb_stage.sv | 109 ++++++++++
 tb/tb_mem_wb_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the MEM/WB stage: writeback-source
// selector, load funct3 encodings, datapath width and the layout of the
// pipeline register captured at the MEM/WB boundary.
package wb_pkg;

  localparam int XLEN = 32;

  // Writeback source selector. The reserved encoding falls back to ALU.
  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_RSVD = 2'd3
  } wb_sel_e;

  // Load funct3 encodings. Any other value is treated as LW.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Everything the WB stage needs from MEM. Load data is kept raw together
  // with the low address bits; extension happens after the register.
  typedef struct packed {
    logic            valid;
    logic            wb_en;
    logic [4:0]      rd;
    wb_sel_e         sel;
    logic [2:0]      funct3;
    logic [1:0]      addr;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] rdata;
  } mem_wb_reg_t;

  // Map a raw 2-bit selector onto the enum, folding reserved onto ALU so
  // every downstream case statement only has three real arms.
  function automatic wb_sel_e decode_sel(input logic [1:0] raw);
    case (raw)
      2'd1:    decode_sel = WB_LOAD;
      2'd2:    decode_sel = WB_PC4;
      default: decode_sel = WB_ALU;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load alignment and extension. Picks the addressed byte or
// halfword out of a word-aligned memory read and sign- or zero-extends it.
// Misaligned halfword addresses are not trapped: addr[0] is simply ignored.
module load_extend
  import wb_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte and halfword lanes of the raw word.
  always_comb begin
    byte_sel = raw[7:0];
    case (addr)
      2'd0: byte_sel = raw[7:0];
      2'd1: byte_sel = raw[15:8];
      2'd2: byte_sel = raw[23:16];
      2'd3: byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase
    half_sel = addr[1] ? raw[31:16] : raw[15:0];
  end

  // Extend the selected lane according to the load type.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through the case can leave it unassigned and infer a latch.
    ext = raw;
    case (funct3)
      F3_LB:   ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  ext = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  ext = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:   ext = raw;
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register plus writeback logic, feeding the register file.
// One cycle of latency MEM->WB; all wb_* and byp_* outputs are
// combinational from the register. flush beats stall; stall holds the
// register, so a held write is simply repeated.
// Optional feature macro: WB_INSTRET_EN enables the retired-instruction
// counter on instret; without it instret is tied to zero.
module mem_wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_valid,
  input  logic             mem_wb_en,
  input  logic [4:0]       mem_rd,
  input  logic [1:0]       mem_wb_sel,
  input  logic [2:0]       mem_funct3,
  input  logic [XLEN-1:0]  mem_alu,
  input  logic [XLEN-1:0]  mem_pc4,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             stall,
  input  logic             flush,
  output logic             wb_en,
  output logic [4:0]       rd_index,
  output logic [XLEN-1:0]  wb_data,
  output logic             byp_valid,
  output logic [4:0]       byp_rd,
  output logic [XLEN-1:0]  byp_data,
  output logic [CNT_W-1:0] instret
);

  mem_wb_reg_t     mem_wb_q;
  mem_wb_reg_t     mem_wb_d;
  logic [XLEN-1:0] load_data;

  // Pack the incoming MEM-stage fields into the register layout.
  always_comb begin
    mem_wb_d        = '0;
    mem_wb_d.valid  = mem_valid;
    mem_wb_d.wb_en  = mem_wb_en;
    mem_wb_d.rd     = mem_rd;
    mem_wb_d.sel    = decode_sel(mem_wb_sel);
    mem_wb_d.funct3 = mem_funct3;
    mem_wb_d.addr   = mem_alu[1:0];
    mem_wb_d.alu    = mem_alu;
    mem_wb_d.pc4    = mem_pc4;
    mem_wb_d.rdata  = mem_rdata;
  end

  // MEM/WB register: flush kills, stall holds, otherwise capture.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the whole register, data fields included, is reset so that
    // wb_data reads 0 during reset rather than whatever was in flight.
    if (!rst_n) begin
      mem_wb_q <= '0;
    end else if (flush) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      mem_wb_q.valid <= 1'b0;
    end else if (!stall) begin
      mem_wb_q <= mem_wb_d;
    end
  end

  load_extend u_load_extend (
    .funct3 (mem_wb_q.funct3),
    .addr   (mem_wb_q.addr),
    .raw    (mem_wb_q.rdata),
    .ext    (load_data)
  );

  // Writeback source mux and register-file write qualification.
  always_comb begin
    wb_data = mem_wb_q.alu;
    case (mem_wb_q.sel)
      WB_LOAD: wb_data = load_data;
      WB_PC4:  wb_data = mem_wb_q.pc4;
      default: wb_data = mem_wb_q.alu;
    endcase
    // Writes to x0 are dropped here so the register file never sees them.
    wb_en    = mem_wb_q.valid & mem_wb_q.wb_en & (mem_wb_q.rd != 5'd0);
    rd_index = mem_wb_q.rd;
  end

  // Same-cycle bypass for ID-stage reads that coincide with this write.
  assign byp_valid = wb_en;
  assign byp_rd    = rd_index;
  assign byp_data  = wb_data;

`ifdef WB_INSTRET_EN
  logic [CNT_W-1:0] instret_q;

  // Count each instruction once, on the edge where it leaves WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (mem_wb_q.valid && !stall) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, ALU/PC4/reserved writeback,
// load extension on every lane, x0 suppression, stall/flush and the
// optional retire counter.
module tb_mem_wb_stage;
  import wb_pkg::*;

  localparam int CNT_W = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mem_valid;
  logic             mem_wb_en;
  logic [4:0]       mem_rd;
  logic [1:0]       mem_wb_sel;
  logic [2:0]       mem_funct3;
  logic [31:0]      mem_alu;
  logic [31:0]      mem_pc4;
  logic [31:0]      mem_rdata;
  logic             stall;
  logic             flush;
  logic             wb_en;
  logic [4:0]       rd_index;
  logic [31:0]      wb_data;
  logic             byp_valid;
  logic [4:0]       byp_rd;
  logic [31:0]      byp_data;
  logic [CNT_W-1:0] instret;

  int vectors     = 0;
  int miscompares = 0;

  mem_wb_stage #(.XLEN(32), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_valid  (mem_valid),
    .mem_wb_en  (mem_wb_en),
    .mem_rd     (mem_rd),
    .mem_wb_sel (mem_wb_sel),
    .mem_funct3 (mem_funct3),
    .mem_alu    (mem_alu),
    .mem_pc4    (mem_pc4),
    .mem_rdata  (mem_rdata),
    .stall      (stall),
    .flush      (flush),
    .wb_en      (wb_en),
    .rd_index   (rd_index),
    .wb_data    (wb_data),
    .byp_valid  (byp_valid),
    .byp_rd     (byp_rd),
    .byp_data   (byp_data),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic en, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [31:0] rdata);
    mem_valid  = v;
    mem_wb_en  = en;
    mem_rd     = rd;
    mem_wb_sel = sel;
    mem_funct3 = f3;
    mem_alu    = alu;
    mem_pc4    = pc4;
    mem_rdata  = rdata;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wb(input string tag, input logic en, input logic [4:0] rd,
                          input logic [31:0] data);
    check({tag, ".wb_en"}, 64'(wb_en), 64'(en));
    if (en) begin
      check({tag, ".rd"},   64'(rd_index), 64'(rd));
      check({tag, ".data"}, 64'(wb_data),  64'(data));
    end
  endtask

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] exp;
  } load_vec_t;

  load_vec_t loads[8];

  initial begin
    loads[0] = '{"lb0",  F3_LB,  2'd0, 32'hFFFF_FF81};
    loads[1] = '{"lbu0", F3_LBU, 2'd0, 32'h0000_0081};
    loads[2] = '{"lb1",  F3_LB,  2'd1, 32'h0000_007F};
    loads[3] = '{"lh2",  F3_LH,  2'd2, 32'hFFFF_80F0};
    loads[4] = '{"lhu3", F3_LHU, 2'd3, 32'h0000_80F0};
    loads[5] = '{"lw",   F3_LW,  2'd0, 32'h80F0_7F81};
    loads[6] = '{"lh1",  F3_LH,  2'd1, 32'h0000_7F81};
    loads[7] = '{"f3x",  3'b011, 2'd2, 32'h80F0_7F81};

    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    rst_n = 1'b0;
    #12;
    check("rst.wb_en",   64'(wb_en),    64'd0);
    check("rst.rd",      64'(rd_index), 64'd0);
    check("rst.data",    64'(wb_data),  64'd0);
    check("rst.instret", instret,       64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU write and bypass mirror.
    drive(1'b1, 1'b1, 5'd5, 2'd0, 3'd0, 32'h0000_1234, 32'h0, 32'h0);
    tick();
    check_wb("alu", 1'b1, 5'd5, 32'h0000_1234);
    check("alu.byp_valid", 64'(byp_valid), 64'd1);
    check("alu.byp_rd",    64'(byp_rd),    64'd5);
    check("alu.byp_data",  64'(byp_data),  64'h1234);

    // Load extension on every lane.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 5'd7, 2'd1, loads[i].f3, {30'h400, loads[i].off},
            32'h0, 32'h80F0_7F81);
      tick();
      check_wb(loads[i].name, 1'b1, 5'd7, loads[i].exp);
    end

    // Write suppression: x0, wb_en low, invalid slot.
    drive(1'b1, 1'b1, 5'd0, 2'd0, 3'd0, 32'hCAFE, 32'h0, 32'h0);
    tick();
    check_wb("x0", 1'b0, 5'd0, 32'h0);
    drive(1'b1, 1'b0, 5'd3, 2'd0, 3'd0, 32'hCAFE, 32'h0, 32'h0);
    tick();
    check_wb("noen", 1'b0, 5'd3, 32'h0);
    drive(1'b0, 1'b1, 5'd3, 2'd0, 3'd0, 32'hCAFE, 32'h0, 32'h0);
    tick();
    check_wb("inval", 1'b0, 5'd3, 32'h0);

    // PC4 and the reserved selector.
    drive(1'b1, 1'b1, 5'd1, 2'd2, 3'd0, 32'hBEEF, 32'h0000_0104, 32'h0);
    tick();
    check_wb("pc4", 1'b1, 5'd1, 32'h0000_0104);
    drive(1'b1, 1'b1, 5'd2, 2'd3, 3'd0, 32'h0000_DEAD, 32'h0000_0200, 32'h0);
    tick();
    check_wb("rsvd", 1'b1, 5'd2, 32'h0000_DEAD);

    // Stall holds for three cycles while the inputs change underneath.
    drive(1'b1, 1'b1, 5'd9, 2'd0, 3'd0, 32'h0000_AAAA, 32'h0, 32'h0);
    tick();
    check_wb("pre_stall", 1'b1, 5'd9, 32'h0000_AAAA);
    stall = 1'b1;
    drive(1'b1, 1'b1, 5'd10, 2'd0, 3'd0, 32'h0000_5555, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_wb($sformatf("stall%0d", i), 1'b1, 5'd9, 32'h0000_AAAA);
    end
    flush = 1'b1;
    tick();
    check_wb("flush", 1'b0, 5'd0, 32'h0);
    stall = 1'b0;
    flush = 1'b0;
    tick();
    check_wb("post_flush", 1'b1, 5'd10, 32'h0000_5555);

    // Asynchronous reset mid-cycle with a write pending.
    drive(1'b1, 1'b1, 5'd12, 2'd0, 3'd0, 32'h0000_7777, 32'h0, 32'h0);
    tick();
    check_wb("pre_rst", 1'b1, 5'd12, 32'h0000_7777);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.wb_en", 64'(wb_en),   64'd0);
    check("arst.data",  64'(wb_data), 64'd0);
    tick();
    check("arst.hold", 64'(wb_en), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Retire counter: ten instructions, two stall cycles interleaved.
    for (int e = 1; e <= 12; e++) begin
      if (e == 4 || e == 8) begin
        stall = 1'b1;
      end else begin
        stall = 1'b0;
      end
      drive(1'b1, 1'b0, 5'd0, 2'd0, 3'd0, 32'(e), 32'h0, 32'h0);
      tick();
    end
    stall = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
`ifdef WB_INSTRET_EN
    check("instret", instret, 64'd10);
`else
    check("instret", instret, 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
